// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter definitions: datapath widths and the per-FU holding-buffer entry.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package cdb_arbiter_pkg;

    typedef struct packed {
        logic                    valid;
        logic [`ROB_TAG_LEN-1:0] tag;
        logic [`XLEN-1:0]        value;
    } cdb_entry_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority picker: one-hot grant to the first request at or after ptr.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]                             req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]     ptr,
    output logic [N-1:0]                             grant
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            if (req[idx] && !found) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry holding buffer per FU, round-robin broadcast onto the common data bus.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FU_NUM = 4
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   flush,
    input  logic [FU_NUM-1:0]                      fu_valid,
    input  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0]    fu_ROB_tag,
    input  logic [FU_NUM-1:0][`XLEN-1:0]           fu_value,
    output logic [FU_NUM-1:0]                      fu_ready,
    output logic [FU_NUM-1:0][`XLEN-1:0]           held_values,
    output logic                                   select_flag,
    output logic [FU_NUM-1:0]                      select_signal,
    output logic [`ROB_TAG_LEN-1:0]                ROB_tag,
    output logic [31:0]                            broadcast_count
);

    localparam int PW = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    cdb_entry_t [FU_NUM-1:0] entry_q;
    logic [FU_NUM-1:0]       req;
    logic [FU_NUM-1:0]       grant;
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           rr_ptr_next;
    logic [31:0]             count_q;

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < FU_NUM; i++) begin
            req[i] = entry_q[i].valid & ~flush;
        end
    end

    rr_picker #(.N(FU_NUM)) u_rr_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // fu_ready is gated by reset_n so it reads 0 while reset is held.
    always_comb begin
        ROB_tag     = '0;
        rr_ptr_next = rr_ptr;
        fu_ready    = '0;
        held_values = '0;
        for (int unsigned i = 0; i < FU_NUM; i++) begin
            held_values[i] = entry_q[i].value;
            fu_ready[i]    = (~entry_q[i].valid | grant[i]) & ~flush & reset_n;
            if (grant[i]) begin
                ROB_tag     = ROB_tag | entry_q[i].tag;
                rr_ptr_next = (i == FU_NUM - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    assign select_flag     = |req;
    assign select_signal   = grant;
    assign broadcast_count = count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_q <= '0;
            rr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < FU_NUM; i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < FU_NUM; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    entry_q[i] <= '{valid: 1'b1, tag: fu_ROB_tag[i], value: fu_value[i]};
                end else if (grant[i]) begin
                    entry_q[i].valid <= 1'b0;
                end
            end
            if (select_flag) begin
                rr_ptr  <= rr_ptr_next;
                count_q <= count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized self-checking bench for cdb_arbiter against a per-cycle behavioural model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_cdb_arbiter;

    localparam int N = 4;

    logic                              clock = 1'b0;
    logic                              reset_n;
    logic                              flush;
    logic [N-1:0]                      fu_valid;
    logic [N-1:0][`ROB_TAG_LEN-1:0]    fu_ROB_tag;
    logic [N-1:0][`XLEN-1:0]           fu_value;
    logic [N-1:0]                      fu_ready;
    logic [N-1:0][`XLEN-1:0]           held_values;
    logic                              select_flag;
    logic [N-1:0]                      select_signal;
    logic [`ROB_TAG_LEN-1:0]           ROB_tag;
    logic [31:0]                       broadcast_count;

    int errors = 0;
    int checks = 0;

    logic                    m_valid [N];
    logic [`ROB_TAG_LEN-1:0] m_tag   [N];
    logic [`XLEN-1:0]        m_val   [N];
    int                      m_wait  [N];
    int                      m_ptr;
    logic [31:0]             m_count;

    logic                    use_fixed = 1'b0;
    logic [`ROB_TAG_LEN-1:0] fixed_tag;
    logic [`XLEN-1:0]        fixed_val;

    cdb_arbiter #(.FU_NUM(N)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .flush           (flush),
        .fu_valid        (fu_valid),
        .fu_ROB_tag      (fu_ROB_tag),
        .fu_value        (fu_value),
        .fu_ready        (fu_ready),
        .held_values     (held_values),
        .select_flag     (select_flag),
        .select_signal   (select_signal),
        .ROB_tag         (ROB_tag),
        .broadcast_count (broadcast_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_val[i]   = '0;
            m_wait[i]  = 0;
        end
        m_ptr   = 0;
        m_count = '0;
    endtask

    // Applies inputs at the negedge, checks combinational outputs, then advances the model across the posedge.
    task automatic cycle(input logic fl, input logic [N-1:0] v);
        int         gi;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_sel;
        flush    = fl;
        fu_valid = v;
        for (int i = 0; i < N; i++) begin
            fu_ROB_tag[i] = `ROB_TAG_LEN'($urandom);
            fu_value[i]   = $urandom;
        end
        if (use_fixed) begin
            fu_ROB_tag[0] = fixed_tag;
            fu_value[0]   = fixed_val;
        end
        #1;
        gi = -1;
        if (!fl) begin
            for (int k = 0; k < N; k++) begin
                if (gi < 0 && m_valid[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
            end
        end
        exp_sel = '0;
        if (gi >= 0) exp_sel[gi] = 1'b1;
        for (int i = 0; i < N; i++) exp_ready[i] = (!m_valid[i] || gi == i) && !fl;

        chk("select_flag", 64'(select_flag), 64'(gi >= 0));
        chk("select_signal", 64'(select_signal), 64'(exp_sel));
        chk("rob_tag", 64'(ROB_tag), (gi >= 0) ? 64'(m_tag[gi]) : 64'd0);
        chk("fu_ready", 64'(fu_ready), 64'(exp_ready));
        chk("count", 64'(broadcast_count), 64'(m_count));
        for (int i = 0; i < N; i++) chk("held_value", 64'(held_values[i]), 64'(m_val[i]));
        if (gi >= 0) chk("starvation", 64'(m_wait[gi] < N), 64'd1);

        @(posedge clock);
        if (fl) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_wait[i]  = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_ready[i]) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = fu_ROB_tag[i];
                    m_val[i]   = fu_value[i];
                    m_wait[i]  = 0;
                end else if (gi == i) begin
                    m_valid[i] = 1'b0;
                    m_wait[i]  = 0;
                end else if (m_valid[i]) begin
                    m_wait[i]++;
                end
            end
            if (gi >= 0) begin
                m_ptr   = (gi + 1) % N;
                m_count = m_count + 32'd1;
            end
        end
        @(negedge clock);
    endtask

    initial begin
        reset_n    = 1'b0;
        flush      = 1'b0;
        fu_valid   = '0;
        fu_ROB_tag = '0;
        fu_value   = '0;
        model_reset();
        #3;
        chk("rst_select_flag", 64'(select_flag), 64'd0);
        chk("rst_fu_ready", 64'(fu_ready), 64'd0);
        chk("rst_count", 64'(broadcast_count), 64'd0);
        #9 reset_n = 1'b1;
        @(negedge clock);

        // Single request with known tag/value.
        use_fixed = 1'b1;
        fixed_tag = `ROB_TAG_LEN'(5);
        fixed_val = 32'hAB;
        cycle(1'b0, 4'b0001);
        use_fixed = 1'b0;
        chk("r36_tag", 64'(ROB_tag), 64'd5);
        chk("r36_sel", 64'(select_signal), 64'b0001);
        cycle(1'b0, 4'b0000);
        chk("r36_idle", 64'(select_flag), 64'd0);
        chk("r36_cnt", 64'(broadcast_count), 64'd1);

        // All four valid from rr_ptr=1 after the single broadcast; drain then idle.
        cycle(1'b0, 4'b1111);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000);
        chk("r37_cnt", 64'(broadcast_count), 64'd5);

        // Back-to-back on FU0.
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0001);
        cycle(1'b0, 4'b0000);

        // Contention: FU1 waits while FU0 and FU2 keep refilling.
        cycle(1'b0, 4'b0111);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0101);

        // Flush with three buffers full.
        cycle(1'b0, 4'b0111);
        cycle(1'b1, 4'b1111);
        cycle(1'b0, 4'b0000);
        chk("flush_empty", 64'(select_flag), 64'd0);

        // Randomized traffic, flush roughly 1 in 16.
        for (int i = 0; i < 400; i++) cycle(($urandom_range(15) == 0), 4'($urandom));

        // Asynchronous reset mid-broadcast.
        cycle(1'b0, 4'b0001);
        fu_valid = '0;
        flush    = 1'b0;
        reset_n  = 1'b0;
        #1;
        model_reset();
        chk("arst_select_flag", 64'(select_flag), 64'd0);
        chk("arst_select_signal", 64'(select_signal), 64'd0);
        chk("arst_rob_tag", 64'(ROB_tag), 64'd0);
        chk("arst_fu_ready", 64'(fu_ready), 64'd0);
        chk("arst_count", 64'(broadcast_count), 64'd0);
        for (int i = 0; i < N; i++) chk("arst_held", 64'(held_values[i]), 64'd0);
        #1 reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(fu_ready), 64'hF);
        @(negedge clock);
        for (int i = 0; i < 40; i++) cycle(1'b0, 4'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter FU_NUM, default 4, sets the number of functional-unit requesters, which is also the CDB input count.
REQ-002 Port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port flush, input, 1 bit: mispredict squash; discards all held results.
REQ-005 Port fu_valid, input, [FU_NUM-1:0]: FU i presents a finished result this cycle.
REQ-006 Port fu_ROB_tag, input, [FU_NUM-1:0][`ROB_TAG_LEN-1:0]: ROB tag per FU result.
REQ-007 Port fu_value, input, [FU_NUM-1:0][`XLEN-1:0]: result value per FU.
REQ-008 Port fu_ready, output, [FU_NUM-1:0]: the FU i result is accepted this cycle when fu_valid[i] and fu_ready[i] are both high.
REQ-009 Port held_values, output, [FU_NUM-1:0][`XLEN-1:0]: buffered values, driven to the CDB value inputs.
REQ-010 Port select_flag, output, 1 bit: a broadcast is valid this cycle.
REQ-011 Port select_signal, output, [FU_NUM-1:0]: one-hot grant; all zeros when select_flag is low.
REQ-012 Port ROB_tag, output, [`ROB_TAG_LEN-1:0]: tag of the granted entry; zero when select_flag is low.
REQ-013 Port broadcast_count, output, 32 bits: number of broadcasts since reset.

Function
REQ-014 Each FU SHALL own a one-entry holding buffer containing buf_valid, tag and value.
REQ-015 fu_ready[i] SHALL equal (~buf_valid[i] | select_signal[i]) & ~flush, combinationally, which allows a drain and a refill in the same cycle.
REQ-016 On an accepted handshake the buffer SHALL capture tag and value at the clock edge; the earliest broadcast is in the next cycle (1-cycle latency).
REQ-017 Grant SHALL be combinational from the buffer state: round-robin over entries with buf_valid set, starting the search at rr_ptr.
REQ-018 select_flag SHALL be high exactly when at least one buf_valid is set and flush is low.
REQ-019 At most one bit of select_signal SHALL be set per cycle.
REQ-020 ROB_tag SHALL equal the tag held in the granted buffer.
REQ-021 held_values[i] SHALL always equal the buffer i value register.
REQ-022 At the edge ending a granted cycle, the granted buf_valid SHALL clear unless the same edge refills it; rr_ptr SHALL become (granted index + 1) mod FU_NUM.
REQ-023 With no grant, rr_ptr SHALL hold its value.
REQ-024 broadcast_count SHALL increment by 1 per granted cycle and wrap from 2^32-1 to 0.
REQ-025 When flush is high, all buf_valid SHALL clear at the edge, incoming fu_valid is dropped, no grant is issued, and rr_ptr and broadcast_count hold.
REQ-026 A buffer that is full and not granted SHALL keep its contents unchanged, and the FU sees fu_ready low.
REQ-027 Starvation bound: a full buffer SHALL be granted within FU_NUM cycles when flush is not asserted.

Reset
REQ-028 While reset_n is low, the block SHALL set all buf_valid, rr_ptr, broadcast_count, buffered tags and buffered values to 0, immediately and without a clock edge.
REQ-029 During reset, select_flag SHALL be 0, select_signal 0, ROB_tag 0, held_values 0 and fu_ready all 0.
REQ-030 fu_ready SHALL return to all 1s in the first cycle after reset_n deasserts.
REQ-031 A reset asserted mid-broadcast SHALL abort it, with no count increment.

Structure
REQ-032 `XLEN and `ROB_TAG_LEN SHALL come from the shared package header.
REQ-033 The buffer entry struct (valid, tag, value) SHALL be declared in the shared package.
REQ-034 The round-robin priority picker SHALL be one sub-module, rr_picker (request vector plus pointer in, one-hot grant out).
REQ-035 The outputs SHALL connect directly to common_data_bus: select_flag, select_signal, ROB_tag, and held_values to in_values.

Verification
REQ-036 Single request: fu_valid=0001 with tag 5 and value 0xAB at cycle 0 SHALL give, in cycle 1, select_flag=1, select_signal=0001 and ROB_tag=5; in cycle 2, select_flag=0 and count=1.
REQ-037 All four FUs valid for one cycle (rr_ptr=0) SHALL give grants 0001, 0010, 0100, 1000 over the next 4 cycles, then idle, with count=4.
REQ-038 Back-to-back: FU0 valid every cycle while granted SHALL keep fu_ready[0]=1 and produce one broadcast per cycle.
REQ-039 Contention: FU1 held continuously while FU0 and FU2 refill SHALL see FU1 granted within 4 cycles, and fu_ready[1]=0 while FU1 waits.
REQ-040 Flush with 3 buffers full and fu_valid=1111 SHALL give select_flag=0 in that cycle and all buffers empty afterwards, with count unchanged.
REQ-041 Asynchronous reset pulse mid-cycle during a broadcast SHALL drive the outputs to 0 immediately; after release, fu_ready=1111 and count=0.
